// File: rtl/jelly2_address_analyzer_nd.sv
// Rebuilds the N-dimensional command descriptor (base, steps, lengths) from an address stream
// that carries per-dimension first/last flags; one descriptor is emitted per frame.
module jelly2_address_analyzer_nd #(
  parameter int unsigned N          = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STEP_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 32,
  parameter bit          LEN_OFFSET = 1'b1,
  parameter int unsigned USER_WIDTH = 0,
  localparam int unsigned USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1
) (
  input  logic                    reset,
  input  logic                    clk,
  input  logic                    cke,
  input  logic [ADDR_WIDTH-1:0]   s_addr,
  input  logic [N-1:0]            s_first,
  input  logic [N-1:0]            s_last,
  input  logic [USER_BITS-1:0]    s_user,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [N*STEP_WIDTH-1:0] m_step,
  output logic [N*LEN_WIDTH-1:0]  m_len,
  output logic [USER_BITS-1:0]    m_user,
  output logic                    m_error,
  output logic                    m_valid,
  input  logic                    m_ready
);

  // Converts a measured element count into the generator's length encoding.
  localparam logic [LEN_WIDTH-1:0] LenAdj = LEN_WIDTH'(LEN_OFFSET) - LEN_WIDTH'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  state_t                               state_q, state_d;
  logic [N-1:0][LEN_WIDTH-1:0]          cnt_q, cnt_d;
  logic [N-1:0][LEN_WIDTH-1:0]          len_cap_q, len_cap_d;
  logic [N-1:0]                         len_vld_q, len_vld_d;
  logic [N-1:0][ADDR_WIDTH-1:0]         row_start_q, row_start_d;
  logic [N-1:0][STEP_WIDTH-1:0]         step_cap_q, step_cap_d;
  logic [N-1:0]                         step_vld_q, step_vld_d;
  logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
  logic [USER_BITS-1:0]                 user_q, user_d;
  logic                                 err_q, err_d;

  logic [N-1:0][STEP_WIDTH-1:0]         step_out_q;
  logic [N-1:0][LEN_WIDTH-1:0]          len_out_q;

  logic                                 accept, frame_start, frame_end;
  logic                                 lo_first, lo_last, prev_first, prev_last;
  logic [ADDR_WIDTH-1:0]                delta;
  logic [STEP_WIDTH-1:0]                step_cur;
  logic [LEN_WIDTH-1:0]                 cnt_cur;

  assign s_ready     = !m_valid || m_ready;
  assign accept      = s_valid && s_ready && cke;
  assign frame_start = (state_q == StIdle);
  assign frame_end   = s_last[N-1];
  assign m_step      = step_out_q;
  assign m_len       = len_out_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_cap_d   = len_cap_q;
    len_vld_d   = len_vld_q;
    row_start_d = row_start_q;
    step_cap_d  = step_cap_q;
    step_vld_d  = step_vld_q;
    addr_d      = addr_q;
    user_d      = user_q;
    err_d       = err_q;
    lo_first    = 1'b1;
    lo_last     = 1'b1;
    prev_first  = 1'b1;
    prev_last   = 1'b1;
    delta       = '0;
    step_cur    = '0;
    cnt_cur     = '0;

    if (accept) begin
      state_d = frame_end ? StIdle : StRun;
      // Per-frame measurements restart on the frame's first beat.
      if (frame_start) begin
        cnt_d      = '0;
        len_cap_d  = '0;
        len_vld_d  = '0;
        step_cap_d = '0;
        step_vld_d = '0;
        addr_d     = s_addr;
        user_d     = s_user;
        err_d      = ~&s_first;
      end

      for (int i = 0; i < N; i++) begin
        if ((s_first[i] && !prev_first) || (s_last[i] && !prev_last)) begin
          err_d = 1'b1;
        end

        if (lo_last) begin
          if (s_last[i]) begin
            cnt_cur  = cnt_d[i] + LEN_WIDTH'(1);
            cnt_d[i] = '0;
            if (!len_vld_d[i]) begin
              len_cap_d[i] = cnt_cur;
              len_vld_d[i] = 1'b1;
            end else if (len_cap_d[i] != cnt_cur) begin
              err_d = 1'b1;
            end
          end else begin
            cnt_d[i] = cnt_d[i] + LEN_WIDTH'(1);
          end
        end

        // A beat that starts a lower row but not a row of dim i advances dim i.
        if (lo_first) begin
          if (!s_first[i]) begin
            delta    = s_addr - row_start_q[i];
            step_cur = STEP_WIDTH'($signed(delta));
            if (!step_vld_d[i]) begin
              step_cap_d[i] = step_cur;
              step_vld_d[i] = 1'b1;
            end else if (step_cap_d[i] != step_cur) begin
              err_d = 1'b1;
            end
          end
          row_start_d[i] = s_addr;
        end

        lo_first   = lo_first & s_first[i];
        lo_last    = lo_last & s_last[i];
        prev_first = s_first[i];
        prev_last  = s_last[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_cap_q   <= '0;
      len_vld_q   <= '0;
      row_start_q <= '0;
      step_cap_q  <= '0;
      step_vld_q  <= '0;
      addr_q      <= '0;
      user_q      <= '0;
      err_q       <= 1'b0;
      m_valid     <= 1'b0;
      m_addr      <= '0;
      step_out_q  <= '0;
      len_out_q   <= '0;
      m_user      <= '0;
      m_error     <= 1'b0;
    end else if (cke) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_cap_q   <= len_cap_d;
      len_vld_q   <= len_vld_d;
      row_start_q <= row_start_d;
      step_cap_q  <= step_cap_d;
      step_vld_q  <= step_vld_d;
      addr_q      <= addr_d;
      user_q      <= user_d;
      err_q       <= err_d;
      if (accept && frame_end) begin
        m_valid    <= 1'b1;
        m_addr     <= addr_d;
        step_out_q <= step_cap_d;
        for (int i = 0; i < N; i++) begin
          len_out_q[i] <= len_cap_d[i] + LenAdj;
        end
        m_user  <= user_d;
        m_error <= err_d;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly2_address_analyzer_nd.sv
// Bench for jelly2_address_analyzer_nd: two instances (LEN_OFFSET 1 and 0) share one stimulus;
// frames are built from descriptors and the analyzers must hand those descriptors back.
module tb_jelly2_address_analyzer_nd;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int SW = 32;
  localparam int LW = 32;
  localparam int UW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cke;
  logic [AW-1:0]   s_addr;
  logic [N-1:0]    s_first, s_last;
  logic [UW-1:0]   s_user;
  logic            s_valid;
  logic            m_ready;

  logic            a_s_ready, b_s_ready;
  logic [AW-1:0]   a_m_addr, b_m_addr;
  logic [N*SW-1:0] a_m_step, b_m_step;
  logic [N*LW-1:0] a_m_len, b_m_len;
  logic [UW-1:0]   a_m_user, b_m_user;
  logic            a_m_error, b_m_error;
  logic            a_m_valid, b_m_valid;

  jelly2_address_analyzer_nd #(
    .N(N), .ADDR_WIDTH(AW), .STEP_WIDTH(SW), .LEN_WIDTH(LW), .LEN_OFFSET(1'b1), .USER_WIDTH(UW)
  ) dut_a (
    .reset(reset), .clk(clk), .cke(cke),
    .s_addr(s_addr), .s_first(s_first), .s_last(s_last), .s_user(s_user),
    .s_valid(s_valid), .s_ready(a_s_ready),
    .m_addr(a_m_addr), .m_step(a_m_step), .m_len(a_m_len), .m_user(a_m_user),
    .m_error(a_m_error), .m_valid(a_m_valid), .m_ready(m_ready)
  );

  jelly2_address_analyzer_nd #(
    .N(N), .ADDR_WIDTH(AW), .STEP_WIDTH(SW), .LEN_WIDTH(LW), .LEN_OFFSET(1'b0), .USER_WIDTH(UW)
  ) dut_b (
    .reset(reset), .clk(clk), .cke(cke),
    .s_addr(s_addr), .s_first(s_first), .s_last(s_last), .s_user(s_user),
    .s_valid(s_valid), .s_ready(b_s_ready),
    .m_addr(b_m_addr), .m_step(b_m_step), .m_len(b_m_len), .m_user(b_m_user),
    .m_error(b_m_error), .m_valid(b_m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      base;
    logic [2:0][31:0] step;
    logic [2:0][7:0]  cnt;
    logic [7:0]       user;
    logic [2:0][31:0] e_step;
    logic [2:0][31:0] e_len1;
    logic [2:0][31:0] e_len0;
  } vec_t;

  typedef struct {
    logic [31:0]      addr;
    logic [2:0][31:0] step;
    logic [2:0][31:0] len1;
    logic [2:0][31:0] len0;
    logic [7:0]       user;
    logic             err;
    logic             only_err;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   rdy_pct = 100, cke_pct = 100, gap_pct = 0;
  logic rdy_force = 1'b0, rdy_val = 1'b1;
  vec_t tbl[6];
  vec_t gen;
  logic acc;
  exp_t e_hand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (cke && a_m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_descriptor: got addr %0h, expected none", a_m_addr);
      end else begin
        e = exp_q.pop_front();
        check("m_valid_b", 64'(b_m_valid), 64'd1);
        check("m_addr", 64'(a_m_addr), 64'(e.addr));
        check("m_error_a", 64'(a_m_error), 64'(e.err));
        check("m_error_b", 64'(b_m_error), 64'(e.err));
        if (!e.only_err) begin
          check("m_user", 64'(a_m_user), 64'(e.user));
          for (int i = 0; i < N; i++) begin
            check($sformatf("m_step_a[%0d]", i), 64'(a_m_step[i*SW +: SW]), 64'(e.step[i]));
            check($sformatf("m_step_b[%0d]", i), 64'(b_m_step[i*SW +: SW]), 64'(e.step[i]));
            check($sformatf("m_len_a[%0d]", i), 64'(a_m_len[i*LW +: LW]), 64'(e.len1[i]));
            check($sformatf("m_len_b[%0d]", i), 64'(b_m_len[i*LW +: LW]), 64'(e.len0[i]));
          end
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, settle, then observe.
  task automatic cycle(input logic v, input logic [31:0] addr, input logic [2:0] f,
                       input logic [2:0] l, input logic [7:0] u, output logic accepted);
    @(negedge clk);
    s_valid = v;
    s_addr  = addr;
    s_first = f;
    s_last  = l;
    s_user  = u;
    m_ready = rdy_force ? rdy_val : ($urandom_range(99) < rdy_pct);
    cke     = ($urandom_range(99) < cke_pct);
    #1;
    accepted = v && a_s_ready && cke;
    monitor();
  endtask

  task automatic send_beat(input logic [31:0] addr, input logic [2:0] f, input logic [2:0] l,
                           input logic [7:0] u);
    logic a;
    while ($urandom_range(99) < gap_pct) cycle(1'b0, 32'h0, 3'b0, 3'b0, 8'h0, a);
    for (int t = 0; t < 200; t++) begin
      cycle(1'b1, addr, f, l, u, a);
      if (a) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL beat_timeout: got no accept, expected accept within 200 cycles");
  endtask

  // Generator-order beat stream for a descriptor; max_beats < 0 sends the whole frame.
  task automatic send_frame(input vec_t v, input int max_beats);
    int n = 0;
    logic [31:0] addr;
    logic [2:0] f, l;
    for (int i2 = 0; i2 < int'(v.cnt[2]); i2++)
      for (int i1 = 0; i1 < int'(v.cnt[1]); i1++)
        for (int i0 = 0; i0 < int'(v.cnt[0]); i0++) begin
          if (max_beats >= 0 && n >= max_beats) return;
          addr = v.base + v.step[0] * 32'(i0) + v.step[1] * 32'(i1) + v.step[2] * 32'(i2);
          f[0] = (i0 == 0);
          f[1] = f[0] && (i1 == 0);
          f[2] = f[1] && (i2 == 0);
          l[0] = (i0 == int'(v.cnt[0]) - 1);
          l[1] = l[0] && (i1 == int'(v.cnt[1]) - 1);
          l[2] = l[1] && (i2 == int'(v.cnt[2]) - 1);
          send_beat(addr, f, l, (f == 3'b111) ? v.user : ~v.user);
          n++;
        end
  endtask

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.addr = v.base; e.step = v.e_step; e.len1 = v.e_len1; e.len0 = v.e_len0;
    e.user = v.user; e.err = 1'b0; e.only_err = 1'b0;
    return e;
  endfunction

  // Reference: a clean frame reproduces its descriptor; a dimension of one element never steps.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.addr = v.base; e.user = v.user; e.err = 1'b0; e.only_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.step[i] = (v.cnt[i] > 1) ? v.step[i] : 32'h0;
      e.len1[i] = 32'(v.cnt[i]);
      e.len0[i] = 32'(v.cnt[i]) - 32'd1;
    end
    return e;
  endfunction

  task automatic drain();
    logic a;
    rdy_force = 1'b1; rdy_val = 1'b1; cke_pct = 100;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) cycle(1'b0, 32'h0, 3'b0, 3'b0, 8'h0, a);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (4) cycle(1'b0, 32'h0, 3'b0, 3'b0, 8'h0, a);
  endtask

  task automatic check_reset_state();
    check("rst_m_valid_a", 64'(a_m_valid), 64'd0);
    check("rst_m_valid_b", 64'(b_m_valid), 64'd0);
    check("rst_m_addr", 64'(a_m_addr), 64'd0);
    check("rst_m_step", 64'(a_m_step[63:0]), 64'd0);
    check("rst_m_len", 64'(a_m_len[63:0]), 64'd0);
    check("rst_m_user", 64'(a_m_user), 64'd0);
    check("rst_m_error", 64'(a_m_error), 64'd0);
    check("rst_s_ready", 64'(a_s_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    //         base          step {d2,d1,d0}                cnt       user   e_step                  e_len1   e_len0
    tbl[0] = '{32'h1000,     {32'h1000, 32'h100, 32'h4},    {8'd2, 8'd2, 8'd3}, 8'hA5,
               {32'h1000, 32'h100, 32'h4}, {32'd2, 32'd2, 32'd3}, {32'd1, 32'd1, 32'd2}};
    tbl[1] = '{32'h55,       {32'h9, 32'h8, 32'h7},         {8'd1, 8'd1, 8'd1}, 8'h3C,
               {32'h0, 32'h0, 32'h0},      {32'd1, 32'd1, 32'd1}, {32'd0, 32'd0, 32'd0}};
    tbl[2] = '{32'h100,      {32'h0, 32'h0, 32'hFFFFFFFC},  {8'd1, 8'd1, 8'd4}, 8'h01,
               {32'h0, 32'h0, 32'hFFFFFFFC}, {32'd1, 32'd1, 32'd4}, {32'd0, 32'd0, 32'd3}};
    tbl[3] = '{32'hFFFFFFF0, {32'h0, 32'h20, 32'h8},        {8'd2, 8'd3, 8'd2}, 8'h7E,
               {32'h0, 32'h20, 32'h8},     {32'd2, 32'd3, 32'd2}, {32'd1, 32'd2, 32'd1}};
    tbl[4] = '{32'h0,        {32'h1, 32'h1, 32'h1},         {8'd2, 8'd2, 8'd2}, 8'hFF,
               {32'h1, 32'h1, 32'h1},      {32'd2, 32'd2, 32'd2}, {32'd1, 32'd1, 32'd1}};
    tbl[5] = '{32'h80000000, {32'h10000, 32'h40, 32'h4},    {8'd3, 8'd1, 8'd2}, 8'h5A,
               {32'h10000, 32'h0, 32'h4},  {32'd3, 32'd1, 32'd2}, {32'd2, 32'd0, 32'd1}};

    reset = 1'b1; cke = 1'b1; s_valid = 1'b0; s_addr = '0; s_first = '0; s_last = '0;
    s_user = '0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    reset = 1'b0;

    // Table-driven frames, back to back.
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(from_vec(tbl[k]));
      send_frame(tbl[k], -1);
    end
    drain();

    // Latency 1, then a held-off descriptor stalls the next frame's first beat.
    rdy_force = 1'b1; rdy_val = 1'b0;
    check("idle_m_valid", 64'(a_m_valid), 64'd0);
    exp_q.push_back(from_vec(tbl[0]));
    send_frame(tbl[0], -1);
    cycle(1'b0, 32'h0, 3'b0, 3'b0, 8'h0, acc);
    check("latency_m_valid_a", 64'(a_m_valid), 64'd1);
    check("latency_m_valid_b", 64'(b_m_valid), 64'd1);
    exp_q.push_back(from_vec(tbl[1]));
    for (int t = 0; t < 5; t++) begin
      cycle(1'b1, 32'h55, 3'b111, 3'b111, 8'h3C, acc);
      check("hold_s_ready_a", 64'(a_s_ready), 64'd0);
      check("hold_s_ready_b", 64'(b_s_ready), 64'd0);
      check("hold_accept", 64'(acc), 64'd0);
    end
    rdy_val = 1'b1;
    cycle(1'b1, 32'h55, 3'b111, 3'b111, 8'h3C, acc);
    check("release_accept", 64'(acc), 64'd1);
    drain();

    // Second row shorter than the first.
    e_hand = '{32'h2000, {32'h0, 32'h100, 32'h4}, {32'd1, 32'd2, 32'd3}, {32'd0, 32'd1, 32'd2},
               8'h11, 1'b1, 1'b0};
    exp_q.push_back(e_hand);
    send_beat(32'h2000, 3'b111, 3'b000, 8'h11);
    send_beat(32'h2004, 3'b000, 3'b000, 8'h22);
    send_beat(32'h2008, 3'b000, 3'b001, 8'h22);
    send_beat(32'h2100, 3'b001, 3'b000, 8'h22);
    send_beat(32'h2104, 3'b000, 3'b111, 8'h22);
    // Frame start without full first flags.
    e_hand = '{32'h10, '0, '0, '0, 8'h0, 1'b1, 1'b1};
    exp_q.push_back(e_hand);
    send_beat(32'h10, 3'b011, 3'b000, 8'h0);
    send_beat(32'h14, 3'b000, 3'b111, 8'h0);
    // The following clean frame must report no error.
    exp_q.push_back(from_vec(tbl[4]));
    send_frame(tbl[4], -1);
    drain();

    // Reset in mid-frame: the partial frame yields nothing.
    send_frame(tbl[0], 5);
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0;
    #1;
    check_reset_state();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(from_vec(tbl[3]));
    send_frame(tbl[3], -1);
    drain();

    // Randomized frames with bubbles, clock-enable gaps and output back-pressure.
    rdy_force = 1'b0; rdy_pct = 70; cke_pct = 85; gap_pct = 30;
    for (int k = 0; k < 40; k++) begin
      gen.base = $urandom;
      for (int i = 0; i < N; i++) begin
        gen.step[i] = $urandom;
        gen.cnt[i]  = 8'($urandom_range(4, 1));
      end
      gen.user = 8'($urandom);
      exp_q.push_back(model(gen));
      send_frame(gen, -1);
    end
    gap_pct = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/jelly2_address_analyzer_nd.md
Name: jelly2_address_analyzer_nd

Overview:
- Receive-side counterpart of the N-dimensional address generator.
- Consumes an address stream carrying per-dimension first/last flags and reconstructs the command descriptor that would have produced it: base address, per-dimension step and per-dimension length.
- Emits one descriptor per frame, i.e. after each beat with s_last[N-1] set, plus a sticky consistency error flag.
- Placed after DMA/address pipelines for self-check and for reverse-engineering access patterns.

Parameters:
- N, 3, number of dimensions.
- ADDR_WIDTH, 32, address width.
- STEP_WIDTH, 32, step width; two's complement, modulo arithmetic.
- LEN_WIDTH, 32, length field width.
- LEN_OFFSET, 1'b1, length encoding: 1 means len = count; 0 means len = count-1 (matches the generator).
- USER_WIDTH, 0, user sideband width. Local USER_BITS = max(USER_WIDTH,1).

Ports:
- reset  input  1  asynchronous, active-high reset
- clk  input  1  clock
- cke  input  1  clock enable; all state holds when 0
- s_addr  input  ADDR_WIDTH  beat address
- s_first  input  N  per-dimension first flags
- s_last  input  N  per-dimension last flags
- s_user  input  USER_BITS  user; captured on frame's first beat
- s_valid  input  1  beat valid
- s_ready  output  1  beat ready
- m_addr  output  ADDR_WIDTH  frame base address (first beat's address)
- m_step  output  N*STEP_WIDTH  measured step per dimension
- m_len  output  N*LEN_WIDTH  measured length per dimension
- m_user  output  USER_BITS  captured user
- m_error  output  1  inconsistency detected in this frame
- m_valid  output  1  descriptor valid
- m_ready  input  1  descriptor ready

Behaviour:
- Reset is asynchronous on reset rising, released synchronously.
  - m_valid=0; m_addr, m_step, m_len, m_user, m_error = 0.
  - Internal counters and captured flags cleared; state = IDLE.
- s_ready = !m_valid || m_ready (combinational). A beat is accepted when s_valid && s_ready && cke.
- States:
  - IDLE (expect frame start).
  - RUN (inside frame).
  - IDLE→RUN on any accepted beat not also ending the frame.
  - Any accepted beat with s_last[N-1] returns to IDLE and loads the output register. m_valid rises the next cycle (latency 1).
  - m_valid clears on m_valid && m_ready && cke unless a new frame end is accepted in the same cycle; in that case the register reloads and m_valid stays 1.
- First beat of a frame:
  - Captures m_addr and s_user.
  - Requires s_first all ones; otherwise error is set.
- Length, per dimension i:
  - cnt[i] increments on accepted beats where s_last[k]=1 for all k<i (every beat for i=0).
  - When s_last[i] is also 1, the element count is cnt[i]+1 and cnt[i] clears.
  - The first completion in a frame captures the count. A later completion in the same frame with a different count sets error; the first captured value is kept.
  - Output m_len[i] = count - 1 + LEN_OFFSET, truncated to LEN_WIDTH.
- Step, per dimension i:
  - row_start[i] holds the address of the last beat having s_first[k]=1 for all k<i (i=0: previous beat).
  - On a beat with s_first[k]=1 for all k<i and s_first[i]=0: delta = s_addr - row_start[i], mod 2^ADDR_WIDTH, truncated/sign-extended to STEP_WIDTH. The first delta captures; a later differing delta sets error.
  - row_start[i] updates on every beat meeting its all-lower-first condition.
  - A dimension that never advances reports step 0.
- Flag checks (set error):
  - s_first[i] && !s_first[i-1], for i>0.
  - s_last[i] && !s_last[i-1], for i>0.
  - Frame-start beat without full s_first.
- Error is per frame: it is cleared at frame start and accumulated into m_error.
- Counter overflow wraps silently. No error is raised for overflow.
- Single-beat frame (first and last all ones): len count=1 in every dimension; all steps 0; error 0.
- Reset mid-frame discards the partial frame. No descriptor is emitted for it.
- Back-to-back frames have no idle cycle. A new first beat may be accepted in the cycle after a frame end.

Test Plan:
- Generator-style 3D frame: base 0x1000, step {4,0x100,0x1000}, counts {3,2,2}, LEN_OFFSET=1, 12 beats, m_ready=1 → one descriptor: m_addr=0x1000, m_step={4,0x100,0x1000}, m_len={3,2,2}, m_error=0, m_valid 1 cycle after the 12th beat.
- Same frame with LEN_OFFSET=0 and m_ready held low for 5 cycles after the descriptor → m_len={2,1,1}; s_ready=0 until m_ready rises; the next frame's first beat stalls, then is accepted with no loss.
- Negative step: base 0x100, step0=-4, 4 beats in one row, N=1 → m_step[0]=0xFFFFFFFC, m_len=4.
- Row 2 shorter (3 then 2 beats in dim0) → m_error=1, m_len[0]=3.
- Single-beat frame (first=last=3'b111, addr 0x55) → m_addr=0x55, m_len={1,1,1}, m_step all 0, m_error=0.
- Reset asserted after 5 beats of a frame, then a full clean frame → exactly one descriptor, matching the clean frame only.
